sync_ram_fifo: RTL and testbench
================================

SYNC_RAM_FIFO -- requirements
Module: sync_ram_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of each stored word.
REQ-002 SHALL have parameter DEPTH, default 256, number of entries; power of two, >= 4.
REQ-003 SHALL have parameter AFULL_LVL, default DEPTH-4, almost_full threshold in entries (FIFO_ALMOST_EN only).
REQ-004 SHALL have parameter AEMPTY_LVL, default 4, almost_empty threshold in entries (FIFO_ALMOST_EN only).
REQ-005 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port wr_en, input, 1, write request.
REQ-008 SHALL have port data_in, input, DATA_WIDTH, write data.
REQ-009 SHALL have port rd_en, input, 1, read request.
REQ-010 SHALL have port data_out, output reg, DATA_WIDTH, read data.
REQ-011 SHALL have ports full and empty, output, 1 each, occupancy flags.
REQ-012 SHALL have port count, output, $clog2(DEPTH)+1, current occupancy.
REQ-013 SHALL have ports overflow and underflow, output, 1 each, one-cycle error pulses.
REQ-014 SHALL have ports almost_full and almost_empty, output, 1 each, present only when FIFO_ALMOST_EN is defined.

Function
REQ-015 SHALL accept a write when wr_en=1 and full=0: data_in stored at wr_ptr, wr_ptr increments.
REQ-016 SHALL accept a read when rd_en=1 and empty=0: word at rd_ptr loaded to data_out at that clock edge (1-cycle latency from rd_en), rd_ptr increments.
REQ-017 SHALL hold data_out unchanged on cycles with no accepted read.
REQ-018 SHALL use pointers of $clog2(DEPTH)+1 bits; low bits address storage, MSB is the wrap bit; pointers wrap DEPTH-1 -> 0 with wrap-bit toggle.
REQ-019 SHALL derive empty = (wr_ptr == rd_ptr); full = low bits equal and wrap bits differ; count = wr_ptr - rd_ptr (modulo pointer width); all registered-state-derived, no input combinational paths.
REQ-020 SHALL, on simultaneous accepted read and write, perform both; count unchanged.
REQ-021 SHALL, when full=1, reject wr_en regardless of rd_en in the same cycle and pulse overflow=1 for one cycle; storage and wr_ptr unchanged.
REQ-022 SHALL, when empty=1, reject rd_en regardless of wr_en in the same cycle and pulse underflow=1 for one cycle; data_out and rd_ptr unchanged (no write-through bypass).
REQ-023 SHALL, when a write and read target the same address in one cycle (impossible unless empty/full), follow REQ-021/022; no read-during-write hazard is reachable.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, set wr_ptr=0, rd_ptr=0, data_out=0, overflow=0, underflow=0; hence empty=1, full=0, count=0, almost_empty=1, almost_full=0.
REQ-025 SHALL give rst priority over wr_en/rd_en; reset mid-stream discards all contents; storage array is not cleared.

Configuration
REQ-026 SHALL with FIFO_ALMOST_EN defined provide almost_full = (count >= AFULL_LVL) and almost_empty = (count <= AEMPTY_LVL); without it, those ports and parameters' logic are absent and all other behaviour is identical.

Structure
REQ-027 SHALL place no typedefs in a shared package; pointer-width constant computed locally via $clog2(DEPTH).
REQ-028 SHALL instantiate one sub-module fifo_mem: single-clock, one write port, one registered read port, DATA_WIDTH x DEPTH, no reset on the array.

Verification
REQ-029 SHALL cover: reset, then write 0x11,0x22,0x33 -> count=3, empty=0; three reads -> data_out 0x11,0x22,0x33 each one cycle after rd_en, then empty=1.
REQ-030 SHALL cover: DEPTH=256, write 256 words -> full=1, count=256; 257th write -> overflow pulse, count stays 256.
REQ-031 SHALL cover: read when empty -> underflow pulse, data_out unchanged; simultaneous wr_en+rd_en when empty -> write accepted, read rejected, count=1.
REQ-032 SHALL cover: count=10, simultaneous write and read for 300 cycles -> count stays 10, pointers wrap, data order preserved.
REQ-033 SHALL cover: rst asserted with count=100 -> next cycle count=0, empty=1, data_out=0; following read -> underflow.
REQ-034 SHALL cover (FIFO_ALMOST_EN): fill to 252 -> almost_full=1 at count 252, 0 at 251; drain to 4 -> almost_empty=1.

Source files
------------

// File: rtl/sync_ram_fifo_pkg.sv
// Shared defaults and elaboration helpers for the single-clock RAM FIFO.
// Holds only constants and a constant function; widths are derived per module.
package sync_ram_fifo_pkg;

    localparam int FIFO_DEF_DATA_WIDTH = 8;
    localparam int FIFO_DEF_DEPTH      = 256;
    localparam int FIFO_AFULL_MARGIN   = 4;
    localparam int FIFO_DEF_AEMPTY_LVL = 4;
    localparam int FIFO_MIN_DEPTH      = 4;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_ram_fifo_mem.sv
// Storage for sync_ram_fifo: one write port, one registered read port.
// The array itself has no reset; only the read register clears.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register holds its value unless a read is accepted.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_ram_fifo.sv
// Single-clock FIFO over a registered-read RAM with wrap-bit pointers.
// Define FIFO_ALMOST_EN to add the almost_full / almost_empty ports.
module sync_ram_fifo
    import sync_ram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DEF_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEF_DEPTH,
    parameter int AFULL_LVL  = DEPTH - FIFO_AFULL_MARGIN,
    parameter int AEMPTY_LVL = FIFO_DEF_AEMPTY_LVL
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
`ifdef FIFO_ALMOST_EN
    ,
    output logic                       almost_full,
    output logic                       almost_empty
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    if (!is_pow2(DEPTH) || DEPTH < FIFO_MIN_DEPTH ||
        AFULL_LVL < 0 || AFULL_LVL > DEPTH ||
        AEMPTY_LVL < 0 || AEMPTY_LVL > DEPTH) begin : g_bad_cfg
        $error("sync_ram_fifo: illegal DEPTH or threshold");
    end

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] wr_ptr_d;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] rd_ptr_d;
    logic          overflow_q;
    logic          overflow_d;
    logic          underflow_q;
    logic          underflow_d;
    logic          wr_ok;
    logic          rd_ok;

    // Flags come only from registered pointers, never from the requests.
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                (wr_ptr_q[AW] != rd_ptr_q[AW]);
        count = wr_ptr_q - rd_ptr_q;
    end

    always_comb begin
        wr_ok       = wr_en && !full;
        rd_ok       = rd_en && !empty;
        wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, wr_ok};
        rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, rd_ok};
        overflow_d  = wr_en && full;
        underflow_d = rd_en && empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

`ifdef FIFO_ALMOST_EN
    always_comb begin
        almost_full  = (count >= PW'(AFULL_LVL));
        almost_empty = (count <= PW'(AEMPTY_LVL));
    end
`endif

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok && !rst),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (data_in),
        .re    (rd_ok),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (data_out)
    );

endmodule

// File: tb/tb_sync_ram_fifo.sv
// Scoreboard bench for sync_ram_fifo (default DEPTH=256, DATA_WIDTH=8).
module tb_sync_ram_fifo;

    localparam int DEPTH = 256;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic [8:0] count;
    logic       overflow;
    logic       underflow;
`ifdef FIFO_ALMOST_EN
    logic       almost_full;
    logic       almost_empty;
`endif

    int vecs = 0;
    int errs = 0;

    logic [7:0] mq[$];
    logic [7:0] expq[$];
    logic [7:0] last_dout = 8'h00;
    bit         exp_ovf = 1'b0;
    bit         exp_unf = 1'b0;
    bit         chk_en = 1'b0;

    sync_ram_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .data_in   (data_in),
        .rd_en     (rd_en),
        .data_out  (data_out),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
`ifdef FIFO_ALMOST_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops the expected read word and checks flags every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            if (expq.size() > 0) last_dout = expq.pop_front();
            cmp("data_out", 32'(data_out), 32'(last_dout));
            cmp("count", 32'(count), 32'(mq.size()));
            cmp("empty", 32'(empty), 32'(mq.size() == 0));
            cmp("full", 32'(full), 32'(mq.size() == DEPTH));
            cmp("overflow", 32'(overflow), 32'(exp_ovf));
            cmp("underflow", 32'(underflow), 32'(exp_unf));
`ifdef FIFO_ALMOST_EN
            cmp("almost_full", 32'(almost_full), 32'(mq.size() >= DEPTH - 4));
            cmp("almost_empty", 32'(almost_empty), 32'(mq.size() <= 4));
`endif
        end
    end

    task automatic cyc(input bit w, input logic [7:0] d, input bit r);
        bit full_m;
        bit empty_m;
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        @(posedge clk);
        full_m  = (mq.size() == DEPTH);
        empty_m = (mq.size() == 0);
        exp_ovf = w && full_m;
        exp_unf = r && empty_m;
        if (r && !empty_m) expq.push_back(mq.pop_front());
        if (w && !full_m) mq.push_back(d);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(posedge clk);
        mq.delete();
        expq.delete();
        last_dout = 8'h00;
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
        chk_en    = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        do_reset();

        cyc(1, 8'h11, 0);
        cyc(1, 8'h22, 0);
        cyc(1, 8'h33, 0);
        cyc(0, 8'h00, 0);
        cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 0);

        for (int i = 0; i < DEPTH; i++) cyc(1, 8'(i), 0);
        cyc(1, 8'hAA, 0);
        cyc(0, 8'h00, 0);
        cyc(1, 8'hBB, 1);
        cyc(1, 8'hCC, 0);
        for (int i = 0; i < DEPTH; i++) cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 0);
        cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 0);
        cyc(1, 8'h5A, 1);
        cyc(0, 8'h00, 0);

        do_reset();
        for (int i = 0; i < 10; i++) cyc(1, 8'(i + 1), 0);
        for (int i = 0; i < 300; i++) cyc(1, 8'(i + 100), 1);
        for (int i = 0; i < 10; i++) cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 0);

        for (int i = 0; i < 100; i++) cyc(1, 8'(i * 3), 0);
        cyc(0, 8'h00, 1);
        do_reset();
        cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 0);
        cyc(0, 8'h00, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
